// File: rtl/adc_capture.sv
// Dual-lane serial ADC sampler for the 105 MHz domain: paces conversions,
// shifts in 16-bit results and hands them to the CDC write port as data_in/fill_data.
module adc_capture #(
    parameter int SAMPLE_PERIOD = 21,
    parameter int CONV_CYCLES   = 3
) (
    input  logic        clk105,
    input  logic        rst,
    input  logic        locked,
    input  logic        enable,
    input  logic        pattern_en,
    input  logic        adc_sdo_a,
    input  logic        adc_sdo_b,
    output logic        adc_convst,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [15:0] data_in,
    output logic        fill_data,
    output logic [15:0] sample_cnt,
    output logic        busy
);

    localparam int PW = $clog2(SAMPLE_PERIOD);

    localparam logic [PW-1:0] P_ZERO      = {PW{1'b0}};
    localparam logic [PW-1:0] P_ONE       = PW'(1);
    localparam logic [PW-1:0] P_CONV_END  = PW'(CONV_CYCLES);
    localparam logic [PW-1:0] P_SHIFT_END = PW'(CONV_CYCLES + 16);
    localparam logic [PW-1:0] P_FILL      = PW'(CONV_CYCLES + 17);
    localparam logic [PW-1:0] P_LAST      = PW'(SAMPLE_PERIOD - 1);
    // LSB of (p - S) equals p[0] xor S[0], so sclk needs only this bit of S
    localparam logic          K_LSB_FLIP  = 1'((CONV_CYCLES + 1) % 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [PW-1:0]   p_r;
    logic [PW-1:0]   p_nx_s;
    logic [1:0]      rst_sync_r;
    logic [7:0]      sh_a_r;
    logic [7:0]      sh_b_r;
    logic [7:0]      sh_a_nx_s;
    logic [7:0]      sh_b_nx_s;
    logic            fill_nx_s;
    logic            sclk_nx_s;
    logic            convst_r;
    logic            cs_n_r;
    logic            sclk_r;
    logic [15:0]     data_r;
    logic            fill_r;
    logic [15:0]     sample_cnt_r;
    logic            busy_r;

    // Reset release synchronizer; assertion is immediate, release takes two clocks
    always_ff @(posedge clk105 or posedge rst) begin
        if (rst) begin
            rst_sync_r <= 2'b11;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b0};
        end
    end

    // FSM state and frame position register
    always_ff @(posedge clk105 or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            p_r     <= P_ZERO;
        end else begin
            state_r <= state_nx_s;
            p_r     <= p_nx_s;
        end
    end

    // Next-state and frame position; loss of lock aborts from any state
    always_comb begin
        state_nx_s = state_r;
        p_nx_s     = p_r;
        if (!locked || rst_sync_r[1]) begin
            state_nx_s = ST_IDLE;
            p_nx_s     = P_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    p_nx_s = P_ZERO;
                    if (enable) begin
                        state_nx_s = ST_CONV;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_CONV: begin
                    p_nx_s = p_r + P_ONE;
                    if (p_r == P_CONV_END) begin
                        state_nx_s = ST_SHIFT;
                    end else begin
                        state_nx_s = ST_CONV;
                    end
                end
                ST_SHIFT: begin
                    p_nx_s = p_r + P_ONE;
                    if (p_r == P_SHIFT_END) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (p_r == P_LAST) begin
                        p_nx_s = P_ZERO;
                        if (enable) begin
                            state_nx_s = ST_CONV;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end else begin
                        p_nx_s     = p_r + P_ONE;
                        state_nx_s = ST_DONE;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    p_nx_s     = P_ZERO;
                end
            endcase
        end
    end

    // Lane shift; a high sclk this cycle means the coming edge drives it low
    always_comb begin
        sh_a_nx_s = sh_a_r;
        sh_b_nx_s = sh_b_r;
        if (sclk_r) begin
            sh_a_nx_s = {sh_a_r[6:0], adc_sdo_a};
            sh_b_nx_s = {sh_b_r[6:0], adc_sdo_b};
        end else begin
            sh_a_nx_s = sh_a_r;
            sh_b_nx_s = sh_b_r;
        end
        fill_nx_s = (state_nx_s == ST_DONE) && (p_nx_s == P_FILL);
        sclk_nx_s = (state_nx_s == ST_SHIFT) && (p_nx_s[0] ^ K_LSB_FLIP);
    end

    // Lane shift registers
    always_ff @(posedge clk105 or posedge rst) begin
        if (rst) begin
            sh_a_r <= 8'h00;
            sh_b_r <= 8'h00;
        end else begin
            sh_a_r <= sh_a_nx_s;
            sh_b_r <= sh_b_nx_s;
        end
    end

    // Registered outputs, decoded from the upcoming state so pins align with p
    always_ff @(posedge clk105 or posedge rst) begin
        if (rst) begin
            convst_r     <= 1'b0;
            cs_n_r       <= 1'b1;
            sclk_r       <= 1'b0;
            busy_r       <= 1'b0;
            fill_r       <= 1'b0;
            data_r       <= 16'h0000;
            sample_cnt_r <= 16'h0000;
        end else begin
            convst_r <= (state_nx_s == ST_CONV) && (p_nx_s == P_ZERO);
            cs_n_r   <= (state_nx_s != ST_SHIFT);
            sclk_r   <= sclk_nx_s;
            busy_r   <= (state_nx_s != ST_IDLE);
            fill_r   <= fill_nx_s;
            if (fill_nx_s) begin
                data_r       <= pattern_en ? sample_cnt_r : {sh_a_nx_s, sh_b_nx_s};
                sample_cnt_r <= sample_cnt_r + 16'h0001;
            end else begin
                data_r       <= data_r;
                sample_cnt_r <= sample_cnt_r;
            end
        end
    end

    assign adc_convst = convst_r;
    assign adc_cs_n   = cs_n_r;
    assign adc_sclk   = sclk_r;
    assign busy       = busy_r;
    assign fill_data  = fill_r;
    assign data_in    = data_r;
    assign sample_cnt = sample_cnt_r;

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: directed frames, a serial ADC model and a
// fill_data monitor that pops expected {data_in, sample_cnt} pairs.
module tb_adc_capture;

    logic        clk105 = 1'b0;
    logic        rst = 1'b0;
    logic        locked = 1'b0;
    logic        enable = 1'b0;
    logic        pattern_en = 1'b0;
    logic        adc_sdo_a;
    logic        adc_sdo_b;
    logic        adc_convst;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [15:0] data_in;
    logic        fill_data;
    logic [15:0] sample_cnt;
    logic        busy;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   fill_cyc_q[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    logic [7:0] adc_a_val = 8'hA5;
    logic [7:0] adc_b_val = 8'h3C;
    logic [7:0] sr_a = 8'h00;
    logic [7:0] sr_b = 8'h00;

    adc_capture dut (
        .clk105     (clk105),
        .rst        (rst),
        .locked     (locked),
        .enable     (enable),
        .pattern_en (pattern_en),
        .adc_sdo_a  (adc_sdo_a),
        .adc_sdo_b  (adc_sdo_b),
        .adc_convst (adc_convst),
        .adc_cs_n   (adc_cs_n),
        .adc_sclk   (adc_sclk),
        .data_in    (data_in),
        .fill_data  (fill_data),
        .sample_cnt (sample_cnt),
        .busy       (busy)
    );

    always #5 clk105 = ~clk105;

    always @(posedge clk105) cyc <= cyc + 1;

    // ADC model: MSB presented at chip select, next bit after each sclk fall
    assign adc_sdo_a = sr_a[7];
    assign adc_sdo_b = sr_b[7];

    always @(negedge adc_cs_n) begin
        sr_a = adc_a_val;
        sr_b = adc_b_val;
    end

    always @(negedge adc_sclk) begin
        #1;
        sr_a = {sr_a[6:0], 1'b0};
        sr_b = {sr_b[6:0], 1'b0};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every fill_data strobe must match the head of the scoreboard
    always @(negedge clk105) begin
        check("sclk_only_with_cs", 32'(adc_sclk & adc_cs_n), 32'd0);
        if (fill_data === 1'b1 && rst === 1'b0) begin
            fill_cyc_q.push_back(cyc);
            check("fill_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("data_in", 32'(data_in), 32'(mon_e.data));
                check("sample_cnt_at_fill", 32'(sample_cnt), 32'(mon_e.cnt));
            end
        end
    end

    task automatic wait_convst(input int budget, output int t);
        int n;
        n = 0;
        while (adc_convst !== 1'b1 && n < budget) begin
            @(negedge clk105);
            n++;
        end
        check("convst_within_budget", 32'(adc_convst), 32'd1);
        t = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk105);
    endtask

    task automatic check_fill_cycle(input string name, input int exp_cyc);
        int fc;
        fc = -1;
        if (fill_cyc_q.size() != 0) fc = fill_cyc_q.pop_front();
        check(name, 32'(fc), 32'(exp_cyc));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data_in"}, 32'(data_in), 32'd0);
        check({tag, "_fill_data"}, 32'(fill_data), 32'd0);
        check({tag, "_convst"}, 32'(adc_convst), 32'd0);
        check({tag, "_cs_n"}, 32'(adc_cs_n), 32'd1);
        check({tag, "_sclk"}, 32'(adc_sclk), 32'd0);
        check({tag, "_sample_cnt"}, 32'(sample_cnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int t0, t1, t2, t3, t4, nconv;
        logic cs_exp, sclk_exp;

        #2 rst = 1'b1;
        #1 check_reset_values("reset");
        repeat (3) @(negedge clk105);
        rst = 1'b0;
        repeat (4) @(negedge clk105);

        // Continuous capture, three frames, enable dropped at p=10 of the third
        exp_q.push_back('{data: 16'hA53C, cnt: 16'h0001});
        exp_q.push_back('{data: 16'hA53C, cnt: 16'h0002});
        exp_q.push_back('{data: 16'hA53C, cnt: 16'h0003});
        locked = 1'b1;
        enable = 1'b1;
        wait_convst(10, t0);
        for (int p = 0; p <= 20; p++) begin
            cs_exp   = !(p >= 4 && p <= 19);
            sclk_exp = (p >= 4 && p <= 19) && (((p - 4) % 2) == 1);
            check($sformatf("convst_p%0d", p), 32'(adc_convst), 32'(p == 0));
            check($sformatf("cs_n_p%0d", p), 32'(adc_cs_n), 32'(cs_exp));
            check($sformatf("sclk_p%0d", p), 32'(adc_sclk), 32'(sclk_exp));
            check($sformatf("busy_p%0d", p), 32'(busy), 32'd1);
            @(negedge clk105);
        end
        wait_until(t0 + 52);
        enable = 1'b0;
        wait_until(t0 + 63);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_cs_n", 32'(adc_cs_n), 32'd1);
        nconv = 0;
        repeat (25) begin
            @(negedge clk105);
            if (adc_convst === 1'b1) nconv++;
        end
        check("no_convst_after_stop", 32'(nconv), 32'd0);
        check("scoreboard_drained_run", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) check_fill_cycle($sformatf("fill_cycle_run%0d", i), t0 + 20 + 21 * i);

        // Pattern mode across the counter wrap
        force dut.sample_cnt_r = 16'hFFFE;
        @(negedge clk105);
        release dut.sample_cnt_r;
        pattern_en = 1'b1;
        exp_q.push_back('{data: 16'hFFFE, cnt: 16'hFFFF});
        exp_q.push_back('{data: 16'hFFFF, cnt: 16'h0000});
        exp_q.push_back('{data: 16'h0000, cnt: 16'h0001});
        enable = 1'b1;
        wait_convst(5, t1);
        wait_until(t1 + 5);
        check("pattern_cs_n_low", 32'(adc_cs_n), 32'd0);
        check("pattern_sclk_high", 32'(adc_sclk), 32'd1);
        wait_until(t1 + 47);
        enable = 1'b0;
        wait_until(t1 + 70);
        check("scoreboard_drained_pattern", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 3; i++) check_fill_cycle($sformatf("fill_cycle_pat%0d", i), t1 + 20 + 21 * i);
        check("pattern_final_cnt", 32'(sample_cnt), 32'd1);

        // Loss of lock mid-SHIFT, then a fresh frame after relock
        pattern_en = 1'b0;
        adc_a_val  = 8'h5A;
        adc_b_val  = 8'hC3;
        enable     = 1'b1;
        wait_convst(5, t2);
        wait_until(t2 + 12);
        locked = 1'b0;
        @(negedge clk105);
        check("abort_cs_n", 32'(adc_cs_n), 32'd1);
        check("abort_sclk", 32'(adc_sclk), 32'd0);
        check("abort_convst", 32'(adc_convst), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_data_hold", 32'(data_in), 32'h0000);
        check("abort_cnt_hold", 32'(sample_cnt), 32'd1);
        repeat (3) @(negedge clk105);
        exp_q.push_back('{data: 16'h5AC3, cnt: 16'h0002});
        locked = 1'b1;
        wait_convst(5, t3);
        check("relock_convst_cycle", 32'(t3), 32'(t2 + 17));
        wait_until(t3 + 5);
        enable = 1'b0;
        wait_until(t3 + 30);
        check("scoreboard_drained_relock", 32'(exp_q.size()), 32'd0);
        check_fill_cycle("fill_cycle_relock", t3 + 20);
        check("no_extra_fills", 32'(fill_cyc_q.size()), 32'd0);

        // Asynchronous reset in the middle of SHIFT
        enable = 1'b1;
        wait_convst(5, t4);
        wait_until(t4 + 10);
        check("pre_reset_cs_n", 32'(adc_cs_n), 32'd0);
        #1 rst = 1'b1;
        #1 check_reset_values("async_reset");
        enable = 1'b0;
        @(negedge clk105);
        rst = 1'b0;
        repeat (4) @(negedge clk105);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("scoreboard_final", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adc_capture.md
# adc_capture

Front-end sampler for the 105 MHz domain. It paces a dual-lane serial ADC at one conversion per `SAMPLE_PERIOD` clocks (5 MS/s at defaults) and shifts in the 16-bit result. It then presents the result as `data_in` with a one-cycle `fill_data` strobe, which is exactly the write-side input pair of the clock-domain conversion stage that feeds the 350 MHz domain. A test-pattern mode replaces ADC data with an incrementing count for bring-up.

## Interface
Parameters:
- `SAMPLE_PERIOD`, 21: clocks per conversion frame. Must satisfy `SAMPLE_PERIOD ≥ CONV_CYCLES + 18`.
- `CONV_CYCLES`, 3: idle clocks between the end of the convst pulse and the start of readout.

Ports:
- `clk105` in 1: the only clock, 105 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `locked` in 1: PLL locked. Low aborts activity.
- `enable` in 1: run request.
- `pattern_en` in 1: 1 = output the sample counter instead of ADC data.
- `adc_sdo_a` in 1: serial lane A, carries bits 15:8, MSB first.
- `adc_sdo_b` in 1: serial lane B, carries bits 7:0, MSB first.
- `adc_convst` out 1: conversion start pulse.
- `adc_cs_n` out 1: ADC chip select, active low.
- `adc_sclk` out 1: serial clock, clk105/2 during readout.
- `data_in` out 16: last captured sample.
- `fill_data` out 1: one-cycle strobe indicating `data_in` is new.
- `sample_cnt` out 16: count of samples delivered, wraps.
- `busy` out 1: a frame is in progress.

## Operation
- Frame counter `p` runs 0..SAMPLE_PERIOD-1 and increments every clock while the frame is active. Let `S = CONV_CYCLES + 1`.
- FSM states:
  - IDLE: `p` is held at 0. Leave IDLE for CONV when `enable & locked`.
  - CONV: covers p = 0..CONV_CYCLES. `adc_convst` = 1 only at p = 0.
  - SHIFT: covers k = p - S = 0..15. `adc_cs_n` = 0 and `adc_sclk` = k[0].
  - DONE: covers p = S+16 .. SAMPLE_PERIOD-1. `fill_data` = 1 at p = S+16 only.
- At the end of the last frame cycle: go to CONV with p = 0 if `enable & locked`, otherwise go to IDLE.
- Capture: on each clk105 edge where `adc_sclk` drives 1→0 (end of odd k), shift `adc_sdo_a` into shift register A and `adc_sdo_b` into shift register B, MSB first. This gives 8 edges per lane.
- At p = S+16, update `data_in` to `{A[7:0], B[7:0]}`, or to `sample_cnt` when `pattern_en` = 1. In the same cycle, assert `fill_data` and increment `sample_cnt` (0xFFFF → 0x0000). Pattern mode keeps the full ADC pin timing.
- `pattern_en` is sampled at p = S+16 only. Changing it mid-frame has no other effect.
- `enable` falling mid-frame: the current frame completes, including `fill_data`. No partial frames.
- `locked` falling in any state: abort immediately. Next cycle: IDLE, p = 0, `adc_cs_n` = 1, `adc_sclk` = 0, `adc_convst` = 0, `busy` = 0, no `fill_data`. `data_in` and `sample_cnt` hold.
- `busy` = 1 in CONV, SHIFT and DONE.

## Timing
- Reset values: `data_in` = 0, `fill_data` = 0, `adc_convst` = 0, `adc_cs_n` = 1, `adc_sclk` = 0, `sample_cnt` = 0, `busy` = 0. FSM = IDLE, p = 0, shift registers = 0.
- Reset is asynchronous on assertion. Its release is synchronized internally with a 2-flop chain; the first frame can start 2 clocks after `rst` falls.
- All outputs are registered with no combinational path from inputs.
- Latency from `enable & locked` high in IDLE to the `adc_convst` pulse is 1 clock.
- `fill_data` rises S+16 clocks after the `adc_convst` pulse: clock 20 at defaults.
- In continuous running, `fill_data` strobes are exactly SAMPLE_PERIOD clocks apart with no gap cycles between frames.
- `fill_data` spacing is ≥ 20 clocks. This satisfies the downstream 4-cycle-per-write minimum.

## Test plan
- Reset, then `locked` = 1, `enable` = 1. The ADC model returns lane A = 0xA5 and lane B = 0x3C. Required: `fill_data` pulses at clocks 20, 41, 62 relative to the first `adc_convst`, each with `data_in` = 0xA53C. `sample_cnt` reads 1, 2, 3.
- Check pin waveforms in one frame. Required: `adc_convst` is high at p = 0 only. `adc_cs_n` is low for p = 4..19. `adc_sclk` shows 8 full periods. No `adc_sclk` activity while `adc_cs_n` = 1.
- Set `pattern_en` = 1 and preload `sample_cnt` to 0xFFFE by running. Required: successive `data_in` values are 0xFFFE, 0xFFFF, 0x0000, and `sample_cnt` wraps to 0.
- Drop `enable` at p = 10. Required: that frame's `fill_data` still occurs at p = 20, then the block goes to IDLE, `busy` = 0, and no further `adc_convst`.
- Drop `locked` at p = 12, during SHIFT. Required: next clock `adc_cs_n` = 1, `adc_sclk` = 0, and no `fill_data` for that frame. `data_in` is unchanged. When `locked` returns, a fresh frame starts at p = 0.
- Assert `rst` mid-SHIFT. Required: all outputs take their reset values asynchronously, before the next clk105 edge.
